// File: rtl/fb_pixel_sink.sv
// Clips rasterizer pixels, maps them to linear framebuffer addresses and queues them for the RAM write port.
// Latency is 2 cycles from pixel to mem_we; the FIFO absorbs mem_ready stalls and drops pixels only when it is full.

// Generic single-clock FIFO that shows its head combinationally and exports its occupancy.
// No internal overflow guard: the caller pushes into a full FIFO only when it pops in the same cycle.
module fb_pixel_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count
);
    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
endmodule

// Pixel sink top: clip, address, FIFO, registered write stage and done tracking.
// frame_done pulses the cycle after the final write handshake; stall warns upstream at DEPTH-2 entries.
module fb_pixel_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_valid,
    input  logic [7:0]        px,
    input  logic [7:0]        py,
    input  logic [23:0]       pixel_color,
    input  logic              shape_done,
    output logic              stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       clip_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ADDR_W + 24;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    state_t            state_next;
    logic              fire;
    logic              in_bounds;
    logic [ADDR_W-1:0] pix_addr;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [EW-1:0]     head_dat;
    logic              mem_we_next;
    logic              drained_next;

    assign in_bounds = (32'(px) < 32'(WIDTH)) && (32'(py) < 32'(HEIGHT));
    assign pix_addr  = ADDR_W'(32'(py) * 32'(WIDTH) + 32'(px));
    assign push_req  = pixel_valid && in_bounds;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    // Refill the write stage whenever it is empty or its current write completes.
    assign pop        = !fifo_empty && (!mem_we || mem_ready);
    assign push       = push_req && (!fifo_full || pop);

    fb_pixel_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({pix_addr, pixel_color}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    assign mem_we_next  = pop || (mem_we && !mem_ready);
    // Looking at post-edge state orders a coincident pixel ahead of its done.
    assign drained_next = (count_next == '0) && !mem_we_next;

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (shape_done) begin
                    if (drained_next) fire = 1'b1;
                    else              state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (drained_next) begin
                    fire       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
            stall      <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            clip_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            frame_done <= fire;
            stall      <= (count_next >= CW'(DEPTH - 2));
            busy       <= (count_next != '0) || mem_we_next || (state_next == FLUSH);
            if (push_req && !push) overflow <= 1'b1;
            if (pixel_valid && !in_bounds && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
            if (pop) begin
                mem_we                <= 1'b1;
                {mem_addr, mem_wdata} <= head_dat;
            end else if (mem_we && mem_ready) begin
                mem_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed bench for fb_pixel_sink: expected writes queued at issue time, checked by a negedge monitor.
module tb_fb_pixel_sink;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  px = '0;
    logic [7:0]  py = '0;
    logic [23:0] pixel_color = '0;
    logic        shape_done = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stall, mem_we, busy, frame_done, overflow;
    logic [14:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [15:0] clip_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_count = 0;
    int fd_count = 0;
    int last_hs_cyc = -10;
    int last_fd_cyc = -10;
    bit toggle_en = 1'b0;
    logic [38:0] exp_q[$];
    bit          held = 1'b0;
    logic [38:0] held_dat;

    fb_pixel_sink dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .px          (px),
        .py          (py),
        .pixel_color (pixel_color),
        .shape_done  (shape_done),
        .stall       (stall),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write handshake against the scoreboard and watches hold stability.
    always @(negedge clk) begin
        if (!reset) begin
            held = 1'b0;
        end else begin
            if (held && mem_we) check("addr_stable", {mem_addr, mem_wdata}, held_dat);
            if (mem_we && mem_ready) begin
                hs_count++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0h want no write", mem_addr, mem_wdata);
                end else begin
                    logic [38:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e[38:24]);
                    check("write_data", mem_wdata, e[23:0]);
                end
            end
            held     = mem_we && !mem_ready;
            held_dat = {mem_addr, mem_wdata};
            if (frame_done) begin
                fd_count++;
                last_fd_cyc = cyc;
                check("fd_pending_writes", exp_q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) mem_ready = ~mem_ready;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c,
                        input bit done, input bit expect_write);
        pixel_valid = 1'b1;
        px = x;
        py = y;
        pixel_color = c;
        shape_done = done;
        if (expect_write) exp_q.push_back({15'(y * 160 + x), c});
        tick();
        pixel_valid = 1'b0;
        shape_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mem_we || busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got still busy want drained within 300 cycles", name);
        end
    endtask

    initial begin
        int fd0, hs0;
        tick();
        tick();
        check("reset_outputs", {stall, mem_we, busy, frame_done, overflow, mem_addr, mem_wdata, clip_count}, 0);
        reset = 1'b1;
        tick();

        // Single pixel (3,2): 2-cycle latency, done one cycle later, frame_done after handshake.
        mem_ready = 1'b1;
        fd0 = fd_count;
        hs0 = hs_count;
        send(8'd3, 8'd2, 24'hFF0000, 1'b0, 1'b1);
        check("lat_early_we", mem_we, 0);
        shape_done = 1'b1;
        tick();
        shape_done = 1'b0;
        check("lat_we", mem_we, 1);
        check("lat_addr", mem_addr, 323);
        check("lat_data", mem_wdata, 24'hFF0000);
        tick();
        check("single_fd_now", frame_done, 1);
        tick();
        check("single_fd_count", fd_count - fd0, 1);
        check("single_hs_count", hs_count - hs0, 1);
        check("single_fd_gap", last_fd_cyc - last_hs_cyc, 1);

        // Clipping.
        hs0 = hs_count;
        send(8'd160, 8'd0, 24'h111111, 1'b0, 1'b0);
        send(8'd0, 8'd120, 24'h222222, 1'b0, 1'b0);
        send(8'd159, 8'd119, 24'h333333, 1'b0, 1'b1);
        wait_idle("clip_drain");
        check("clip_count", clip_count, 2);
        check("clip_overflow", overflow, 0);
        check("clip_hs_count", hs_count - hs0, 1);

        // Back-pressure: 20 stalled cycles, 12 pixels, last 3 dropped.
        mem_ready = 1'b0;
        hs0 = hs_count;
        for (int i = 0; i < 12; i++) begin
            send(8'(i), 8'd1, 24'h100000 + 24'(i), 1'b0, i < 9);
            check($sformatf("bp_stall_%0d", i), stall, (i >= 6));
            check($sformatf("bp_overflow_%0d", i), overflow, (i >= 9));
        end
        for (int i = 0; i < 8; i++) tick();
        check("bp_no_writes_stalled", hs_count - hs0, 0);
        mem_ready = 1'b1;
        wait_idle("bp_drain");
        check("bp_hs_count", hs_count - hs0, 9);
        check("bp_overflow_sticky", overflow, 1);

        // Coincident pixel and done with mem_ready toggling.
        fd0 = fd_count;
        toggle_en = 1'b1;
        send(8'd10, 8'd20, 24'h00FF00, 1'b0, 1'b1);
        send(8'd11, 8'd20, 24'h00FF01, 1'b0, 1'b1);
        send(8'd12, 8'd20, 24'h0000FF, 1'b1, 1'b1);
        wait_idle("toggle_drain");
        toggle_en = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        check("toggle_fd_count", fd_count - fd0, 1);
        check("toggle_fd_after_hs", last_fd_cyc > last_hs_cyc, 1);

        // Reset with 5 pixels buffered.
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(i + 40), 8'd5, 24'hABC000 + 24'(i), 1'b0, 1'b0);
        check("rst_pre_we", mem_we, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_outputs", {stall, mem_we, busy, frame_done, overflow, mem_addr, mem_wdata, clip_count}, 0);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 6; i++) tick();
        check("rst_no_stale", hs_count - hs0, 0);
        send(8'd0, 8'd0, 24'h00ABCD, 1'b0, 1'b1);
        check("rst_lat_early_we", mem_we, 0);
        tick();
        check("rst_lat_we", mem_we, 1);
        check("rst_lat_addr", mem_addr, 0);
        wait_idle("rst_drain");

        // Done with an empty pipeline fires on the next cycle.
        fd0 = fd_count;
        shape_done = 1'b1;
        tick();
        shape_done = 1'b0;
        check("empty_fd_now", frame_done, 1);
        tick();
        check("empty_fd_clear", frame_done, 0);
        check("empty_fd_count", fd_count - fd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fb_pixel_sink.md
# fb_pixel_sink

Consumer end of the rasterizer pixel stream: accepts `pixel_valid`/`px`/`py`/`pixel_color`/`done` from a shape unit (line, rect, circle), clips against the screen, and converts each pixel to a linear framebuffer address. A FIFO absorbs memory back-pressure, because the shape units have no ready input. Entries drain to the framebuffer RAM port through a valid/ready handshake. After the shape's last pixel is committed, the block emits one `frame_done` pulse.

## Interface
- `WIDTH`, 160: screen width in pixels; pixels with `px >= WIDTH` are clipped.
- `HEIGHT`, 120: screen height in pixels; pixels with `py >= HEIGHT` are clipped.
- `ADDR_W`, 15: framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- `DEPTH`, 8: FIFO entries; must be a power of 2 and at least 4.
- `clk`  in  1  the single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pixel_valid`  in  1  a pixel is presented this cycle.
- `px`, `py`  in  8 each  pixel coordinates.
- `pixel_color`  in  24  RGB888 colour.
- `shape_done`  in  1  one-cycle pulse from the shape unit.
- `stall`  out  1  FIFO occupancy >= DEPTH-2; upstream must hold off `start` while it is high.
- `mem_we`  out  1  write request valid.
- `mem_addr`  out  ADDR_W  write address, `py*WIDTH + px`.
- `mem_wdata`  out  24  write colour.
- `mem_ready`  in  1  RAM accepts the write this cycle.
- `busy`  out  1  the FIFO or output stage holds data, or a done is pending.
- `frame_done`  out  1  one-cycle pulse after the shape is fully committed.
- `overflow`  out  1  sticky; set when an in-bounds pixel is dropped because the FIFO is full.
- `clip_count`  out  16  saturating count of clipped pixels.

## Operation
- Reset value of every output is 0. Reset clears the FIFO pointers, the output stage, `done_pending`, `clip_count` and `overflow`.
- Asserting reset mid-stream discards all buffered pixels, with no partial write. `mem_we` drops asynchronously.

Push path:
- Condition: `pixel_valid` and in-bounds.
- Address is computed in full width, then truncated to ADDR_W: `{py}*WIDTH + {px}`.
- The FIFO entry is {addr, colour}.
- When the FIFO is full, a push succeeds only if a pop occurs in the same cycle. Otherwise the pixel is dropped and `overflow` is set.

Clip path:
- An out-of-bounds pixel is never pushed.
- `clip_count` increments and saturates at 16'hFFFF.

Output stage:
- A registered `mem_we`/`mem_addr`/`mem_wdata` stage sits after the FIFO.
- It loads from the FIFO head (a pop) when it is empty, or when the current write is accepted (`mem_we && mem_ready`).
- `mem_addr`/`mem_wdata` must stay stable while `mem_we && !mem_ready`.

Done FSM:
- IDLE: waiting for `shape_done`.
  - `shape_done` -> FLUSH, setting `done_pending`.
- FLUSH: waiting for the pipeline to drain.
  - When the FIFO is empty and the output stage is empty or being accepted this cycle, assert `frame_done` for 1 cycle -> IDLE.
- A `shape_done` that coincides with a `pixel_valid` orders the pixel before the done; that pixel must be committed before `frame_done`.
- Extra `shape_done` pulses while in FLUSH merge into a single `frame_done`.
- `shape_done` arriving with an empty pipeline produces `frame_done` on the next cycle.

## Timing
- Latency: `pixel_valid` in cycle N, with an empty FIFO and output stage, gives `mem_we` high in cycle N+2. FIFO write happens at edge N, output load at edge N+1.
- Throughput: 1 pixel per cycle while `mem_ready` = 1.
- `frame_done` rises no earlier than 1 cycle after the cycle in which the last write handshake (`mem_we && mem_ready`) occurs.
- `stall` and `busy` are registered. They reflect occupancy at the previous edge.
- Simultaneous push and pop with a full FIFO leaves occupancy unchanged, with no overflow.

## Test plan
- Single pixel (3,2), colour 24'hFF0000, `mem_ready`=1:
  - `mem_we` high exactly 2 cycles later with `mem_addr`=323 and `mem_wdata`=FF0000.
  - `shape_done` 1 cycle after the pixel -> `frame_done` one cycle after the write handshake.
- Clip: pixels (160,0), (0,120) and (159,119):
  - Only addr 19199 is written.
  - `clip_count`=2.
  - `overflow`=0.
- Back-pressure: `mem_ready`=0 for 20 cycles while 12 consecutive in-bounds pixels are presented:
  - `stall` rises at occupancy 6.
  - After the FIFO (8) and output stage (1) fill, 3 pixels are dropped and `overflow`=1.
  - After `mem_ready`=1, exactly 9 writes appear, in order, with `mem_addr` held stable throughout the stall.
- Simultaneous `pixel_valid` and `shape_done` on the final pixel with `mem_ready` toggling 1/0:
  - `frame_done` fires only after that pixel's handshake.
  - Exactly one pulse.
- Reset (low) asserted while 5 pixels are buffered:
  - All outputs read 0 immediately.
  - After release, no stale writes occur.
  - A new pixel (0,0) writes addr 0 with 2-cycle latency.
